serial_deserializer: RTL

- Serial-in, parallel-out word assembler that sits directly downstream of the enabled D flip-flop stage.
- Consumes the flop's registered bit stream (d) qualified by the same enable strobe (en).
- Packs WIDTH bits into a word, presents it with a valid/ack handshake, and flags overrun when an unaccepted word is overwritten.

---
 rtl/serial_deserializer_pkg.sv | 12 +
 rtl/serial_deserializer_mod_counter.sv | 42 ++++
 rtl/serial_deserializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared defaults and bit-order encoding for the serial deserializer.
package serial_deserializer_pkg;

    localparam int unsigned SD_DEFAULT_WIDTH = 8;

    // Which end of the word the first received bit lands in.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

endpackage

// File: rtl/serial_deserializer_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and a wrap strobe.
// The wrap strobe marks the edge at which the counter rolls N-1 -> 0.
module mod_counter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         last;

    assign last  = (count_q == W'(N - 1));
    assign wrap  = en & ~clr & last;
    assign count = count_q;

    // Next count: clear dominates, otherwise step on enable and wrap at N-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    // Counter register, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out word assembler with valid/ack handshake and a
// sticky overrun flag for words overwritten before they were accepted.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SD_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     d,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     ack,
    output logic [WIDTH-1:0]         data,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    count_w;
    logic             bit_accept;
    logic             done;

    // A bit is only consumed when clear is not competing for the same edge.
    assign bit_accept = en & ~clr;

    // Bit counter also produces the completion strobe for the WIDTH-th bit.
    mod_counter #(
        .N (WIDTH),
        .W (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst),
        .en    (en),
        .clr   (clr),
        .count (count_w),
        .wrap  (done)
    );

    // Shift direction is fixed at elaboration time.
    generate
        if (MSB_FIRST == ORDER_MSB_FIRST) begin : g_msb_first
            assign shifted = {shreg_q[WIDTH-2:0], d};
        end else begin : g_lsb_first
            assign shifted = {d, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state for shift register, output word, handshake and overrun.
    always_comb begin
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clr) begin
            shreg_d = '0;
        end else if (bit_accept) begin
            shreg_d = shifted;
        end

        if (done) begin
            // A simultaneous ack retires the old word, so no overrun then.
            data_d  = shifted;
            valid_d = 1'b1;
            if (valid_q && !ack) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        if (clr) begin
            overrun_d = 1'b0;
        end
    end

    // State registers, all asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign count   = count_w;
    assign overrun = overrun_q;

endmodule
